fdd_drive_emu: RTL and testbench



---
 rtl/fdd_drive_emu_pkg.sv | 21 ++
 rtl/fdd_mfm_serializer.sv | 78 +++++++
 rtl/fdd_drive_emu.sv | 200 ++++++++++++++++++++
 tb/tb_fdd_drive_emu.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdd_drive_emu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fdd_drive_emu_pkg
//  Purpose  : Shared types and constants for the floppy drive emulator.
//  Revision : 1.0 - initial release
// ============================================================================
package fdd_drive_emu_pkg;

    typedef enum logic [1:0] {
        FDD_OFF      = 2'd0,
        FDD_SPINUP   = 2'd1,
        FDD_SPINNING = 2'd2
    } fdd_motor_t;

    // Filler byte emitted when the track buffer misses a byte deadline.
    localparam logic [7:0]  FDD_GAP_BYTE      = 8'h4E;
    // Clock cell of data bit 2; dropping it turns A1 into the 0x4489 sync mark.
    localparam logic [15:0] FDD_SYNC_CLK_MASK = 16'h0020;

endpackage
`default_nettype wire

// File: rtl/fdd_mfm_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : fdd_mfm_serializer
//  Purpose  : MFM-encodes one byte per 16 cells and stretches 1-cells into
//             flux pulses.
//  Revision : 1.0 - initial release
// ============================================================================
module fdd_mfm_serializer
    import fdd_drive_emu_pkg::*;
#(
    parameter int PULSE_CLKS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       i_run,
    input  logic       i_shift,
    input  logic [3:0] i_cell,
    input  logic       i_load,
    input  logic [7:0] i_byte,
    input  logic       i_sync,
    output logic       o_flux
);

    localparam int                  c_CNT_W = $clog2(PULSE_CLKS + 1);
    localparam logic [c_CNT_W-1:0]  c_PULSE = c_CNT_W'(PULSE_CLKS);

    logic [15:0]        r_word;
    logic               r_dprev;
    logic [c_CNT_W-1:0] r_pulse_cnt;
    logic [15:0]        w_enc;
    logic               w_cell_bit;

    // Cells are packed first-sent in bit 15: (clock, data) per bit, MSB first.
    function automatic logic [15:0] mfm_encode(input logic [7:0] b,
                                               input logic       prev,
                                               input logic       sync);
        logic [15:0] w;
        logic        p;
        w = '0;
        p = prev;
        for (int i = 7; i >= 0; i--) begin
            w[2*i+1] = ~(p | b[i]);
            w[2*i]   = b[i];
            p        = b[i];
        end
        if (sync) begin
            w = w & ~FDD_SYNC_CLK_MASK;
        end
        return w;
    endfunction

    assign w_enc      = mfm_encode(i_byte, r_dprev, i_sync);
    assign w_cell_bit = r_word[4'd15 - i_cell];
    assign o_flux     = (r_pulse_cnt != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_word      <= '0;
            r_dprev     <= 1'b0;
            r_pulse_cnt <= '0;
        end else begin
            if (!i_run) begin
                r_pulse_cnt <= '0;
            end else if (i_shift && w_cell_bit) begin
                r_pulse_cnt <= c_PULSE;
            end else if (r_pulse_cnt != '0) begin
                r_pulse_cnt <= r_pulse_cnt - 1'b1;
            end
            // The last cell of the old word is emitted on the same strobe.
            if (i_load) begin
                r_word  <= w_enc;
                r_dprev <= i_byte[0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fdd_drive_emu.sv
`default_nettype none
// ============================================================================
//  Module   : fdd_drive_emu
//  Purpose  : Drive side of the floppy interface: head, spindle, index,
//             spin-up timing and MFM read stream fed from a track buffer.
//  Revision : 1.0 - initial release
// ============================================================================
module fdd_drive_emu
    import fdd_drive_emu_pkg::*;
#(
    parameter logic DRIVE_ID    = 1'b0,
    parameter int   MAX_TRACK   = 81,
    parameter int   TRACK_BYTES = 6250,
    parameter int   INDEX_BYTES = 125,
    parameter int   SPINUP_MS   = 250,
    parameter int   PULSE_CLKS  = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ce_cell,
    input  logic        ce_1k,
    input  logic        USEL,
    input  logic        MOTORn,
    input  logic        STEPn,
    input  logic        SDIRn,
    input  logic        SIDEn,
    output logic        READYn,
    output logic        INDEXn,
    output logic        TRACK0n,
    output logic        WPROTn,
    output logic        READ_DATAn,
    input  logic        img_mounted,
    input  logic        img_readonly,
    input  logic [63:0] img_size,
    output logic [6:0]  cur_track,
    output logic        cur_side,
    output logic        byte_rq,
    output logic [12:0] byte_addr,
    input  logic        byte_valid,
    input  logic [7:0]  byte_data,
    input  logic        byte_sync,
    output logic        underrun
);

    localparam int                 c_SPIN_W    = $clog2(SPINUP_MS + 1);
    localparam logic [c_SPIN_W-1:0] c_SPIN_LAST = c_SPIN_W'(SPINUP_MS - 1);
    localparam logic [6:0]         c_MAX_TRK   = 7'(MAX_TRACK);
    localparam logic [12:0]        c_LAST_POS  = 13'(TRACK_BYTES - 1);
    localparam logic [12:0]        c_INDEX_LEN = 13'(INDEX_BYTES);

    // Media latch survives reset; only a new mount changes it.
    logic r_present = 1'b0;
    logic r_ro      = 1'b0;

    fdd_motor_t          r_motor;
    logic [c_SPIN_W-1:0] r_spin_cnt;
    logic                r_stepn_q;
    logic [6:0]          r_track;
    logic [3:0]          r_cell;
    logic [12:0]         r_pos;
    logic                r_rq_done;
    logic                r_byte_rq;
    logic [12:0]         r_byte_addr;
    logic                r_side;
    logic                r_outstanding;
    logic                r_have;
    logic [7:0]          r_data;
    logic                r_sync;
    logic                r_underrun;

    logic        w_sel;
    logic        w_step;
    logic        w_rotating;
    logic        w_shift;
    logic        w_wrap;
    logic        w_rq;
    logic [12:0] w_next_addr;
    logic        w_flux;

    assign w_sel       = (USEL == DRIVE_ID);
    assign w_step      = w_sel && r_stepn_q && !STEPn;
    assign w_rotating  = (r_motor == FDD_SPINNING) && r_present;
    assign w_shift     = w_rotating && ce_cell;
    assign w_wrap      = w_shift && (r_cell == 4'd15);
    assign w_next_addr = (r_pos == c_LAST_POS) ? 13'd0 : r_pos + 13'd1;
    // One fetch per byte slot, issued while the cell counter sits at 0.
    assign w_rq        = w_rotating && (r_cell == 4'd0) && !r_rq_done;

    always_ff @(posedge clk) begin
        if (img_mounted) begin
            r_present <= (img_size != 64'd0);
            r_ro      <= img_readonly;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stepn_q <= 1'b1;
            r_track   <= '0;
        end else begin
            r_stepn_q <= STEPn;
            if (w_step) begin
                if (!SDIRn) begin
                    if (r_track < c_MAX_TRK) r_track <= r_track + 7'd1;
                end else if (r_track != 7'd0) begin
                    r_track <= r_track - 7'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || MOTORn) begin
            r_motor    <= FDD_OFF;
            r_spin_cnt <= '0;
        end else begin
            case (r_motor)
                FDD_OFF:    r_motor <= FDD_SPINUP;
                FDD_SPINUP: begin
                    if (ce_1k) begin
                        if (r_spin_cnt == c_SPIN_LAST) r_motor <= FDD_SPINNING;
                        else                           r_spin_cnt <= r_spin_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cell        <= '0;
            r_pos         <= '0;
            r_rq_done     <= 1'b0;
            r_byte_rq     <= 1'b0;
            r_byte_addr   <= '0;
            r_side        <= 1'b0;
            r_outstanding <= 1'b0;
            r_have        <= 1'b0;
            r_data        <= '0;
            r_sync        <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_rq_done <= w_rotating && (r_cell == 4'd0);
            r_byte_rq <= w_rq;
            if (w_rq) begin
                r_byte_addr <= w_next_addr;
                r_side      <= !SIDEn;
            end
            if (!w_rotating) begin
                r_cell <= '0;
            end else if (w_shift) begin
                r_cell <= r_cell + 4'd1;
            end
            if (w_wrap) begin
                r_pos <= w_next_addr;
                if (!r_have) r_underrun <= 1'b1;
            end
            // A response is only valid between its request and the next boundary.
            if (!w_rotating || w_wrap) begin
                r_outstanding <= 1'b0;
                r_have        <= 1'b0;
            end else if (w_rq) begin
                r_outstanding <= 1'b1;
            end else if (byte_valid && r_outstanding) begin
                r_outstanding <= 1'b0;
                r_have        <= 1'b1;
                r_data        <= byte_data;
                r_sync        <= byte_sync;
            end
        end
    end

    fdd_mfm_serializer #(
        .PULSE_CLKS (PULSE_CLKS)
    ) u_ser (
        .clk     (clk),
        .reset   (reset),
        .i_run   (w_rotating),
        .i_shift (w_shift),
        .i_cell  (r_cell),
        .i_load  (w_wrap),
        .i_byte  (r_have ? r_data : FDD_GAP_BYTE),
        .i_sync  (r_have && r_sync),
        .o_flux  (w_flux)
    );

    assign READYn     = !(w_sel && (r_motor == FDD_SPINNING) && r_present);
    assign INDEXn     = !(w_sel && w_rotating && (r_pos < c_INDEX_LEN));
    assign TRACK0n    = !(w_sel && (r_track == 7'd0));
    assign WPROTn     = !(w_sel && (r_ro || !r_present));
    assign READ_DATAn = !(w_sel && w_flux);
    assign cur_track  = r_track;
    assign cur_side   = r_side;
    assign byte_rq    = r_byte_rq;
    assign byte_addr  = r_byte_addr;
    assign underrun   = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_fdd_drive_emu.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fdd_drive_emu
//  Purpose  : Directed/randomized bench for fdd_drive_emu with a cell-level
//             reference model of head, index and MFM read stream.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fdd_drive_emu;

    localparam int TRK_BYTES = 20;
    localparam int IDX_BYTES = 3;
    localparam int PCLK      = 3;
    localparam int MAXT      = 81;
    localparam int SPIN      = 250;
    localparam int WH_IDX    = 6;

    logic        clk = 1'b0;
    logic        reset, ce_cell, ce_1k, USEL, MOTORn, STEPn, SDIRn, SIDEn;
    logic        img_mounted, img_readonly, byte_valid, byte_sync;
    logic [63:0] img_size;
    logic [7:0]  byte_data;
    logic        READYn, INDEXn, TRACK0n, WPROTn, READ_DATAn;
    logic [6:0]  cur_track;
    logic        cur_side, byte_rq, underrun;
    logic [12:0] byte_addr;

    always #5 clk = ~clk;

    fdd_drive_emu #(
        .DRIVE_ID (1'b0), .MAX_TRACK (MAXT), .TRACK_BYTES (TRK_BYTES),
        .INDEX_BYTES (IDX_BYTES), .SPINUP_MS (SPIN), .PULSE_CLKS (PCLK)
    ) dut (
        .clk (clk), .reset (reset), .ce_cell (ce_cell), .ce_1k (ce_1k),
        .USEL (USEL), .MOTORn (MOTORn), .STEPn (STEPn), .SDIRn (SDIRn),
        .SIDEn (SIDEn), .READYn (READYn), .INDEXn (INDEXn), .TRACK0n (TRACK0n),
        .WPROTn (WPROTn), .READ_DATAn (READ_DATAn), .img_mounted (img_mounted),
        .img_readonly (img_readonly), .img_size (img_size), .cur_track (cur_track),
        .cur_side (cur_side), .byte_rq (byte_rq), .byte_addr (byte_addr),
        .byte_valid (byte_valid), .byte_data (byte_data), .byte_sync (byte_sync),
        .underrun (underrun)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    bit          sel_m;
    int          m_track;
    bit          model_on;
    int          cells_done;
    int          rq_idx;
    logic [15:0] cur_word;
    logic [15:0] obs_word;
    bit          m_dprev;
    bit          m_underrun;
    bit          m_side;
    logic [15:0] word_q[$];
    bit          wh_q[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Cells in transmit order, first cell in bit 15.
    function automatic logic [15:0] mfm_model(input logic [7:0] b, input logic s);
        logic [15:0] w;
        bit prev, c, d;
        w    = '0;
        prev = m_dprev;
        for (int k = 0; k < 8; k++) begin
            d = b[7-k];
            c = !(prev || d);
            if (s && (7 - k) == 2) c = 1'b0;
            w[15-2*k] = c;
            w[14-2*k] = d;
            prev      = d;
        end
        m_dprev = prev;
        return w;
    endfunction

    // One clock; also plays the track buffer when a fetch request shows up.
    task automatic tick();
        int         pos;
        logic [7:0] b;
        logic       s;
        bit         wh;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        if (model_on && byte_rq === 1'b1) begin
            pos = (cells_done / 16) % TRK_BYTES;
            check("byte_addr", byte_addr, (pos + 1) % TRK_BYTES);
            check("cur_side_rq", cur_side, !SIDEn);
            m_side = !SIDEn;
            wh = (rq_idx == WH_IDX);
            case (rq_idx)
                1:       begin b = 8'($urandom) & 8'hFE; s = 1'b0; end
                2:       begin b = 8'h00; s = 1'b0; end
                3:       begin b = 8'hA1; s = 1'b1; end
                default: begin b = 8'($urandom); s = ($urandom_range(0, 7) == 0); end
            endcase
            if (wh) begin
                b = 8'h4E;
                s = 1'b0;
            end else begin
                byte_valid = 1'b1;
                byte_data  = b;
                byte_sync  = s;
            end
            word_q.push_back(mfm_model(b, s));
            wh_q.push_back(wh);
            rq_idx++;
        end
    endtask

    task automatic do_step(input bit dir);
        SDIRn = dir; STEPn = 1'b0;
        tick(); tick();
        STEPn = 1'b1;
        tick(); tick();
        if (sel_m) m_track = dir ? ((m_track > 0) ? m_track - 1 : 0)
                                 : ((m_track < MAXT) ? m_track + 1 : MAXT);
        check("cur_track", cur_track, m_track);
        check("TRACK0n", TRACK0n, !(sel_m && m_track == 0));
    endtask

    task automatic spinup(input bit check_each);
        MOTORn = 1'b0;
        tick();
        for (int i = 1; i <= SPIN; i++) begin
            ce_1k = 1'b1; tick(); ce_1k = 1'b0; tick();
            if (check_each || i == SPIN) check("READYn_spinup", READYn, (i < SPIN));
        end
    endtask

    task automatic cell_step();
        int c, pos, slot;
        bit bitv;
        c    = cells_done % 16;
        bitv = cur_word[15-c];
        slot = cells_done / 16;
        if (c == 8 && slot % 5 == 2) begin
            byte_valid = 1'b1; byte_data = 8'hFF; byte_sync = 1'b1;
        end
        if (c == 10) SIDEn = 1'($urandom);
        ce_cell = 1'b1; tick(); ce_cell = 1'b0;
        cells_done++;
        obs_word = {obs_word[14:0], ~READ_DATAn};
        if (c == 15) begin
            check("rq_before_wrap", (word_q.size() != 0), 1'b1);
            if (word_q.size() != 0) begin
                cur_word = word_q.pop_front();
                if (wh_q.pop_front()) m_underrun = 1'b1;
            end
            if (slot == 3) check("cells_00", obs_word, 16'hAAAA);
            if (slot == 4) check("cells_A1_sync", obs_word, 16'h4489);
            if (slot == 7) check("cells_gap_4E", obs_word[14:0], 15'h1254);
        end
        if (c == 12) check("cur_side_hold", cur_side, m_side);
        pos = (cells_done / 16) % TRK_BYTES;
        check("READ_DATAn", READ_DATAn, !(sel_m && bitv));
        check("INDEXn", INDEXn, !(sel_m && pos < IDX_BYTES));
        check("READYn", READYn, !sel_m);
        check("underrun", underrun, m_underrun);
        tick(); tick();
        check("READ_DATAn_width", READ_DATAn, !(sel_m && bitv));
        tick();
        check("READ_DATAn_end", READ_DATAn, 1'b1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: run did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ce_cell = 1'b0; ce_1k = 1'b0; USEL = 1'b1; MOTORn = 1'b1;
        STEPn = 1'b1; SDIRn = 1'b0; SIDEn = 1'b1; img_mounted = 1'b0;
        img_readonly = 1'b0; img_size = '0; byte_valid = 1'b0; byte_data = '0;
        byte_sync = 1'b0; model_on = 1'b0; sel_m = 1'b0; m_track = 0;
        obs_word = '0;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();
        check("rst_READYn", READYn, 1'b1);
        check("rst_INDEXn", INDEXn, 1'b1);
        check("rst_TRACK0n", TRACK0n, 1'b1);
        check("rst_WPROTn", WPROTn, 1'b1);
        check("rst_READ_DATAn", READ_DATAn, 1'b1);
        check("rst_cur_track", cur_track, 7'd0);
        check("rst_cur_side", cur_side, 1'b0);
        check("rst_byte_rq", byte_rq, 1'b0);
        check("rst_byte_addr", byte_addr, 13'd0);
        check("rst_underrun", underrun, 1'b0);

        USEL = 1'b0; sel_m = 1'b1;
        tick();
        check("TRACK0n_sel", TRACK0n, 1'b0);
        check("WPROTn_nodisk", WPROTn, 1'b0);

        for (int i = 0; i < 3; i++) do_step(1'b0);
        check("track_after_in3", cur_track, 7'd3);
        for (int i = 0; i < 5; i++) do_step(1'b1);
        check("track_after_out5", cur_track, 7'd0);
        for (int i = 0; i < 90; i++) do_step(1'b0);
        check("track_saturate", cur_track, 7'd81);
        for (int i = 0; i < 40; i++) do_step(1'($urandom));

        img_mounted = 1'b1; img_size = 64'd737280; img_readonly = 1'b0;
        tick(); img_mounted = 1'b0; tick();
        check("WPROTn_rw", WPROTn, 1'b1);
        img_mounted = 1'b1; img_readonly = 1'b1;
        tick(); img_mounted = 1'b0; img_readonly = 1'b0; tick();
        check("WPROTn_ro", WPROTn, 1'b0);
        check("READYn_motor_off", READYn, 1'b1);

        spinup(1'b1);
        MOTORn = 1'b1;
        tick();
        check("READYn_motor_drop", READYn, 1'b1);
        check("INDEXn_motor_drop", INDEXn, 1'b1);

        reset = 1'b1; tick(); tick(); reset = 1'b0; tick();
        m_track = 0;
        check("rst2_cur_track", cur_track, 7'd0);
        check("rst2_WPROTn_kept", WPROTn, 1'b0);

        model_on = 1'b1; cells_done = 0; rq_idx = 0; cur_word = '0;
        m_dprev = 1'b0; m_underrun = 1'b0; m_side = 1'b0;
        spinup(1'b0);
        for (int i = 0; i < 2 * TRK_BYTES * 16; i++) cell_step();

        USEL = 1'b1; sel_m = 1'b0;
        tick();
        check("desel_READYn", READYn, 1'b1);
        check("desel_TRACK0n", TRACK0n, 1'b1);
        check("desel_WPROTn", WPROTn, 1'b1);
        do_step(1'b0);
        for (int i = 0; i < 24; i++) cell_step();
        USEL = 1'b0; sel_m = 1'b1;
        for (int i = 0; i < 24; i++) cell_step();

        model_on = 1'b0;
        img_mounted = 1'b1; img_size = 64'd0;
        tick(); img_mounted = 1'b0; tick();
        check("eject_READYn", READYn, 1'b1);
        check("eject_WPROTn", WPROTn, 1'b0);
        check("eject_INDEXn", INDEXn, 1'b1);
        check("eject_READ_DATAn", READ_DATAn, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
